// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined ripple-carry adder/subtractor with valid/ready stream ports
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = WIDTH / STAGES;

  // Register index k holds the result of stage k (i.e. pipeline register k+1).
  // Operands are carried whole; b is stored already inverted for subtract so
  // later stages and the overflow flag never need to know the mode.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  opa_q  [STAGES];
  logic [WIDTH-1:0]  opa_d  [STAGES];
  logic [WIDTH-1:0]  opb_q  [STAGES];
  logic [WIDTH-1:0]  opb_d  [STAGES];
  logic [WIDTH-1:0]  psum_q [STAGES];
  logic [WIDTH-1:0]  psum_d [STAGES];

  logic en;

  // Whole pipeline advances together; a full output slot that is not being
  // drained freezes every stage, bubbles included.
  assign en       = !valid_q[STAGES-1] || out_ready;
  assign in_ready = en;

  // Each stage ripples one CW-bit chunk on top of its predecessor's register.
  always_comb begin
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_s;
    logic             src_c;
    logic             src_v;
    logic [CW:0]      part;

    valid_d = valid_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    psum_d  = psum_q;

    src_a = a;
    src_b = b ^ {WIDTH{sub}};
    src_s = '0;
    src_c = cin ^ sub;
    src_v = in_valid && in_ready;

    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, src_a[k*CW +: CW]} + {1'b0, src_b[k*CW +: CW]} + {{CW{1'b0}}, src_c};
      if (en) begin
        valid_d[k]              = src_v;
        opa_d[k]                = src_a;
        opb_d[k]                = src_b;
        psum_d[k]               = src_s;
        psum_d[k][k*CW +: CW]   = part[CW-1:0];
        carry_d[k]              = part[CW];
      end
      src_a = opa_q[k];
      src_b = opb_q[k];
      src_s = psum_q[k];
      src_c = carry_q[k];
      src_v = valid_q[k];
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        opa_q[i]  <= '0;
        opb_q[i]  <= '0;
        psum_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      psum_q  <= psum_d;
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign sum       = psum_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = (opa_q[STAGES-1][WIDTH-1] == opb_q[STAGES-1][WIDTH-1]) &&
                     (psum_q[STAGES-1][WIDTH-1] != opa_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - scoreboard bench for pipe_adder at (8,1), (16,4), (32,8)
module tb_pipe_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  localparam int NRAND = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_v, in_valid_v, cin_v, sub_v, out_ready_v, manual_v;
  logic [2:0]  in_ready_v, out_valid_v, cout_v, ovf_v;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  logic [7:0]  sum0;
  logic [15:0] sum1;
  logic [31:0] sum2;

  exp_t exp_q [3][$];
  int   widths [3] = '{8, 16, 32};
  int   n_checks = 0;
  int   n_fail   = 0;

  pipe_adder #(.WIDTH(8), .STAGES(1)) u_w8 (
    .clk(clk), .rst(rst_v[0]), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .cin(cin_v[0]), .sub(sub_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .sum(sum0), .cout(cout_v[0]), .ovf(ovf_v[0]));

  pipe_adder #(.WIDTH(16), .STAGES(4)) u_w16 (
    .clk(clk), .rst(rst_v[1]), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1][15:0]), .b(b_v[1][15:0]), .cin(cin_v[1]), .sub(sub_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .sum(sum1), .cout(cout_v[1]), .ovf(ovf_v[1]));

  pipe_adder #(.WIDTH(32), .STAGES(8)) u_w32 (
    .clk(clk), .rst(rst_v[2]), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .sub(sub_v[2]),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
    .sum(sum2), .cout(cout_v[2]), .ovf(ovf_v[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] lane_sum(input int l);
    case (l)
      0:       return {24'h0, sum0};
      1:       return {16'h0, sum1};
      default: return sum2;
    endcase
  endfunction

  // Reference: integer arithmetic on the operand values, signed overflow as range check.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic cin, input logic sub);
    longint lim, ua, ub, sa, sbv, ci, t, r;
    exp_t   e;
    lim = longint'(1) << (w - 1);
    ua  = longint'(a);
    ub  = longint'(b);
    ci  = cin ? 64'sd1 : 64'sd0;
    sa  = (ua >= lim) ? ua - 2 * lim : ua;
    sbv = (ub >= lim) ? ub - 2 * lim : ub;
    if (sub) begin
      t      = ua - ub - ci;
      r      = sa - sbv - ci;
      e.cout = (t >= 0);
    end else begin
      t      = ua + ub + ci;
      r      = sa + sbv + ci;
      e.cout = (t >= 2 * lim);
    end
    e.sum = 32'(t & (2 * lim - 1));
    e.ovf = (r >= lim) || (r < -lim);
    return e;
  endfunction

  function automatic logic [31:0] rand_op(input int w);
    logic [31:0] m, top;
    m   = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    top = 32'h1 << (w - 1);
    case ($urandom % 8)
      0:       return 32'h0;
      1:       return m;
      2:       return top;
      3:       return top - 32'h1;
      default: return $urandom & m;
    endcase
  endfunction

  // Monitor: pop-and-compare on every output transfer, push model result on every input transfer.
  always @(negedge clk) begin
    exp_t e;
    for (int l = 0; l < 3; l++) begin
      if (rst_v[l]) begin
        exp_q[l].delete();
      end else begin
        if (out_valid_v[l] && out_ready_v[l]) begin
          if (exp_q[l].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL lane%0d unexpected output: sum=0x%0h, no beat outstanding", l, lane_sum(l));
          end else begin
            e = exp_q[l].pop_front();
            check($sformatf("lane%0d sum", l), lane_sum(l), e.sum);
            check($sformatf("lane%0d cout", l), {31'h0, cout_v[l]}, {31'h0, e.cout});
            check($sformatf("lane%0d ovf", l), {31'h0, ovf_v[l]}, {31'h0, e.ovf});
          end
        end
        if (in_valid_v[l] && in_ready_v[l] && !manual_v[l])
          exp_q[l].push_back(model(widths[l], a_v[l], b_v[l], cin_v[l], sub_v[l]));
      end
    end
  end

  task automatic drive_random(input int l);
    int acc = 0;
    int cyc = 0;
    while (acc < NRAND && cyc < 40000) begin
      in_valid_v[l]  = ($urandom % 4) != 0;
      a_v[l]         = rand_op(widths[l]);
      b_v[l]         = rand_op(widths[l]);
      cin_v[l]       = 1'($urandom);
      sub_v[l]       = 1'($urandom);
      out_ready_v[l] = ($urandom % 4) != 0;
      @(negedge clk);
      if (in_valid_v[l] && in_ready_v[l]) acc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid_v[l]  = 1'b0;
    out_ready_v[l] = 1'b1;
    check($sformatf("lane%0d random beats accepted", l), acc, NRAND);
  endtask

  // Directed beat on the 16/4 lane with a hand-computed expected result.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                      input logic [15:0] es, input logic ec, input logic eo);
    int guard = 0;
    in_valid_v[1] = 1'b1;
    a_v[1] = {16'h0, a};
    b_v[1] = {16'h0, b};
    cin_v[1] = cin;
    sub_v[1] = sub;
    @(negedge clk);
    while (!in_ready_v[1] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("send accept timeout", 32'h0, 32'h1);
    exp_q[1].push_back('{sum: {16'h0, es}, cout: ec, ovf: eo});
    @(posedge clk);
    #1;
    in_valid_v[1] = 1'b0;
  endtask

  task automatic run_stream(input int st, input int len, input int span);
    int i = 1;
    int c = 0;
    int outs = 0;
    int first = -1;
    int last = -1;
    while ((i <= 8 || outs < 8) && c < 80) begin
      in_valid_v[1]  = (i <= 8);
      a_v[1]         = 32'(i);
      b_v[1]         = 32'(i);
      cin_v[1]       = 1'b0;
      sub_v[1]       = 1'b0;
      out_ready_v[1] = !(c >= st && c < st + len);
      @(negedge clk);
      if (out_valid_v[1] && out_ready_v[1]) begin
        if (first < 0) first = c;
        last = c;
        outs++;
      end
      if (!out_ready_v[1]) begin
        check("stall out_valid", {31'h0, out_valid_v[1]}, 32'h1);
        check("stall in_ready", {31'h0, in_ready_v[1]}, 32'h0);
      end
      if (in_valid_v[1] && in_ready_v[1]) begin
        exp_q[1].push_back('{sum: 32'(2 * i), cout: 1'b0, ovf: 1'b0});
        i++;
      end
      @(posedge clk);
      #1;
      c++;
    end
    in_valid_v[1]  = 1'b0;
    out_ready_v[1] = 1'b1;
    check("stream output count", outs, 8);
    check("stream output span", last - first, span);
  endtask

  task automatic directed();
    int seen = 0;
    manual_v[1]    = 1'b1;
    out_ready_v[1] = 1'b1;

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("latency not early", {31'h0, out_valid_v[1]}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("latency out_valid", {31'h0, out_valid_v[1]}, 32'h1);
    @(posedge clk);
    #1;

    send(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send(16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    repeat (8) @(posedge clk);
    #1;

    run_stream(0, 0, 7);
    run_stream(6, 3, 10);

    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    send(16'h0100, 16'h0001, 1'b1, 1'b1, 16'h00FE, 1'b1, 1'b0);
    send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    rst_v[1]      = 1'b1;
    in_valid_v[1] = 1'b1;
    a_v[1]        = 32'h0000_ABCD;
    b_v[1]        = 32'h0000_0001;
    @(posedge clk);
    #1;
    rst_v[1]      = 1'b0;
    in_valid_v[1] = 1'b0;
    @(negedge clk);
    check("post-reset out_valid", {31'h0, out_valid_v[1]}, 32'h0);
    check("post-reset sum", {16'h0, sum1}, 32'h0);
    check("post-reset cout", {31'h0, cout_v[1]}, 32'h0);
    check("post-reset ovf", {31'h0, ovf_v[1]}, 32'h0);
    check("post-reset in_ready", {31'h0, in_ready_v[1]}, 32'h1);
    repeat (12) begin
      @(negedge clk);
      if (out_valid_v[1]) seen++;
    end
    check("no pre-reset beat emerges", seen, 0);
    @(posedge clk);
    #1;
    manual_v[1] = 1'b0;
  endtask

  initial begin
    rst_v       = 3'b111;
    in_valid_v  = 3'b000;
    cin_v       = 3'b000;
    sub_v       = 3'b000;
    out_ready_v = 3'b111;
    manual_v    = 3'b000;
    for (int l = 0; l < 3; l++) begin
      a_v[l] = 32'h0;
      b_v[l] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset w8 out_valid", {31'h0, out_valid_v[0]}, 32'h0);
    check("reset w16 out_valid", {31'h0, out_valid_v[1]}, 32'h0);
    check("reset w32 out_valid", {31'h0, out_valid_v[2]}, 32'h0);
    check("reset in_ready", {29'h0, in_ready_v}, 32'h7);
    check("reset cout", {29'h0, cout_v}, 32'h0);
    check("reset ovf", {29'h0, ovf_v}, 32'h0);
    check("reset w8 sum", {24'h0, sum0}, 32'h0);
    check("reset w16 sum", {16'h0, sum1}, 32'h0);
    check("reset w32 sum", sum2, 32'h0);
    @(posedge clk);
    #1;
    rst_v = 3'b000;

    fork
      drive_random(0);
      begin
        directed();
        drive_random(1);
      end
      drive_random(2);
    join

    repeat (20) @(posedge clk);
    @(negedge clk);
    for (int l = 0; l < 3; l++)
      check($sformatf("lane%0d drained", l), exp_q[l].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined ripple-carry adder/subtractor with a valid/ready stream interface. It generalises the single-bit full adder to WIDTH bits. Carry propagation is split across STAGES register stages, and the block accepts one operand pair per clock. It sits in the arithmetic datapath between an operand source and a result consumer, and it tolerates backpressure from the consumer.

## Interface
- WIDTH, 16: operand and result width in bits. Must be ≥ 2.
- STAGES, 4: number of pipeline stages. Must divide WIDTH. Chunk size CW = WIDTH/STAGES.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A (unsigned or two's complement).
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  mode: 0 = add, 1 = subtract.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry-out. In sub mode: 1 = no borrow.
- ovf  out  1  two's-complement signed overflow.

## Operation
- Add: {cout, sum} = a + b + cin.
- Sub: {cout, sum} = a + ~b + ~cin, i.e. a − b − cin, with cout = NOT borrow.
- ovf = (A_msb == B'_msb) && (sum_msb != A_msb), where B' = b in add mode and ~b in sub mode.
- Pipeline layout:
  - Stage k (k = 0..STAGES−1) adds bits [k·CW +: CW] using the carry from stage k−1. Stage 0 uses the effective carry-in (cin or ~cin).
  - Stage k writes its partial sum and carry into pipeline register k+1.
  - Unconsumed operand chunks travel alongside in the registers. Already-computed low sum chunks also travel forward.
  - Each register carries a valid bit.
  - Register STAGES drives sum, cout, ovf and out_valid directly. There is no combinational path from a, b or cin to any output.
- Flow control uses a global advance enable: en = !out_valid || out_ready.
  - in_ready = en. It is combinational from out_valid and out_ready only, and never depends on in_valid.
  - When en = 1, every register loads from its predecessor. Register 1 loads the valid bit in_valid && in_ready.
  - When en = 0, all registers hold. Internal bubbles are not collapsed.
- A beat transfers in on any edge where in_valid && in_ready. A beat transfers out on any edge where out_valid && out_ready.
- Simultaneous input accept and output drain in the same cycle is allowed, giving full throughput of 1 beat/cycle.
- In sub mode, sum wraps modulo 2^WIDTH. No saturation.
- Beat ordering is strictly preserved.

## Timing
- Reset: on any edge with rst = 1, all valid bits clear and all data registers clear. After that edge, out_valid = 0, sum = 0, cout = 0, ovf = 0, in_ready = 1.
- rst overrides en. Beats in flight are discarded, and a beat presented in the same cycle as rst is not accepted.
- Latency: a beat accepted on edge E appears on the outputs after edge E+STAGES−1, assuming no stall.
  - STAGES = 1 gives a single registered stage and 1-cycle latency.
- Stall: sum, cout, ovf and out_valid stay stable while out_valid && !out_ready.
- Held-output rule: outputs change only on an edge with en = 1. In this codebase's output-stable rule, once out_valid = 1 the value is held until accepted.
- Critical path: one CW-bit ripple chain plus the mux into the register.

## Test plan
- Carry across chunks (WIDTH=16, STAGES=4): a=0xFFFF, b=0x0001, cin=0, sub=0 → sum=0x0000, cout=1, ovf=0. out_valid rises 3 edges after the accepting edge.
- Subtract with borrow: a=0x0005, b=0x0007, cin=0, sub=1 → sum=0xFFFE, cout=0, ovf=0. Then a=0x0005, b=0x0005, cin=1, sub=1 → sum=0xFFFF, cout=0.
- Signed overflow: a=0x7FFF, b=0x0001, add → sum=0x8000, ovf=1. Also a=0x8000, b=0x0001, sub → sum=0x7FFF, ovf=1.
- Streaming and backpressure:
  - Drive 8 back-to-back beats a=i, b=i, i=1..8, with out_ready=1 → 8 consecutive results 2, 4, …, 16 with no gaps.
  - Repeat with out_ready dropped for 3 cycles mid-stream → in_ready=0 during the stall, no beat lost or duplicated, and order preserved.
- Reset mid-operation: accept 3 beats, assert rst for 1 cycle with in_valid=1 → next cycle out_valid=0, sum=0, in_ready=1. No pre-reset beat ever appears.
- Randomised: 10k random a, b, cin, sub with random out_ready, checked against a reference model. Repeat for (WIDTH, STAGES) = (8, 1), (16, 4), (32, 8).
